// File: rtl/watchdog_pkg.sv
// Shared types and helpers for the watchdog recovery supervisor.
package watchdog_pkg;

    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_RESET   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    function automatic int unsigned ms_to_cycles(input longint unsigned freq,
                                                 input longint unsigned ms);
        return int'(freq * ms / 64'd1000);
    endfunction

    // Counter width able to hold values 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic logic [31:0] lowest_onehot(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/watchdog_supervisor_sup_down_counter.sv
// Loadable down-counter that stops at zero.
module sup_down_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             load,
    input  logic             en,
    input  logic [Width-1:0] load_val,
    output logic             zero
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/watchdog_supervisor.sv
// Recovery sequencer for a bank of watchdogs: trip, reset pulse, hold-off,
// monitor, with retry escalation to a latched fault.
module watchdog_supervisor
    import watchdog_pkg::*;
#(
    parameter int unsigned Clk_Frequency     = 50_000_000,
    parameter int unsigned Channels          = 4,
    parameter int unsigned ResetPulse_Cycles = 16,
    parameter int unsigned Holdoff_ms        = 100,
    parameter int unsigned Stable_ms         = 1000,
    parameter int unsigned MaxRetries        = 3
) (
    input  logic                                   ipClk,
    input  logic                                   ipReset,
    input  logic [Channels-1:0]                    ipError,
    input  logic [Channels-1:0]                    ipMask,
    input  logic                                   ipClear,
    output logic                                   opSysReset,
    output logic                                   opWdReset,
    output logic [Channels-1:0]                    opCause,
    output logic [clog2_min1(MaxRetries+1)-1:0]    opRetries,
    output logic                                   opFault,
    output logic [1:0]                             opState
);

    localparam int unsigned PulseCyc  = ResetPulse_Cycles;
    localparam int unsigned HoldCyc   = ms_to_cycles(Clk_Frequency, Holdoff_ms);
    localparam int unsigned StableCyc = ms_to_cycles(Clk_Frequency, Stable_ms);
    localparam int unsigned TW = clog2_min1((PulseCyc > HoldCyc) ? PulseCyc : HoldCyc);
    localparam int unsigned SW = clog2_min1(StableCyc);
    localparam int unsigned RW = clog2_min1(MaxRetries + 1);

    state_e              state_q, state_d;
    logic                sys_reset_q, sys_reset_d;
    logic                wd_reset_q, wd_reset_d;
    logic [Channels-1:0] cause_q, cause_d;
    logic [RW-1:0]       retries_q, retries_d;
    logic                fault_q, fault_d;

    logic          tmr_load, tmr_en, tmr_zero;
    logic [TW-1:0] tmr_val;
    logic          stb_load, stb_en, stb_zero;

    logic [Channels-1:0] masked;
    logic                trig;

    assign masked = ipError & ipMask;
    assign trig   = |masked;

    // One timer serves both the reset pulse and the hold-off window;
    // it is reloaded on each entry to either state.
    sup_down_counter #(.Width(TW)) u_phase_tmr (
        .clk      (ipClk),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    sup_down_counter #(.Width(SW)) u_stable_tmr (
        .clk      (ipClk),
        .load     (stb_load),
        .en       (stb_en),
        .load_val (SW'(StableCyc - 1)),
        .zero     (stb_zero)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        retries_d = retries_q;
        fault_d   = fault_q;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_val   = TW'(PulseCyc - 1);
        stb_load  = 1'b0;
        stb_en    = 1'b0;

        if (ipReset) begin
            state_d   = ST_RESET;
            tmr_load  = 1'b1;
            retries_d = '0;
            cause_d   = '0;
            fault_d   = 1'b0;
        end else begin
            case (state_q)
                ST_MONITOR: begin
                    if (trig) begin
                        cause_d = Channels'(lowest_onehot(32'(masked)));
                        if (retries_q == RW'(MaxRetries)) begin
                            state_d = ST_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d   = ST_RESET;
                            retries_d = retries_q + RW'(1);
                            tmr_load  = 1'b1;
                        end
                    end else if (stb_zero) begin
                        retries_d = '0;
                        stb_load  = 1'b1;
                    end else begin
                        stb_en = 1'b1;
                    end
                end
                ST_RESET: begin
                    if (tmr_zero) begin
                        state_d  = ST_HOLDOFF;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(HoldCyc - 1);
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (tmr_zero) begin
                        state_d  = ST_MONITOR;
                        stb_load = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (ipClear) begin
                        state_d   = ST_RESET;
                        tmr_load  = 1'b1;
                        retries_d = '0;
                        cause_d   = '0;
                        fault_d   = 1'b0;
                    end
                end
                default: state_d = ST_RESET;
            endcase
        end

        sys_reset_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
        wd_reset_d  = (state_d == ST_RESET);
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q     <= ST_RESET;
            sys_reset_q <= 1'b1;
            wd_reset_q  <= 1'b1;
            cause_q     <= '0;
            retries_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sys_reset_q <= sys_reset_d;
            wd_reset_q  <= wd_reset_d;
            cause_q     <= cause_d;
            retries_q   <= retries_d;
            fault_q     <= fault_d;
        end
    end

    assign opSysReset = sys_reset_q;
    assign opWdReset  = wd_reset_q;
    assign opCause    = cause_q;
    assign opRetries  = retries_q;
    assign opFault    = fault_q;
    assign opState    = state_q;

endmodule

// File: doc/watchdog_supervisor.md
Name: watchdog_supervisor

Overview:
Sequences recovery for a bank of watchdog timers. It takes each watchdog's error output and decides which subsystem reset to issue. It then re-arms the watchdogs and grants a hold-off window before monitoring resumes. Repeated trips escalate to a latched fault. The block sits between the watchdog instances and the system reset tree.

Parameters:
Clk_Frequency, 50_000_000, ipClk frequency in Hz.
Channels, 4, number of watchdog error inputs (>=1).
ResetPulse_Cycles, 16, opSysReset pulse length in cycles (>=1).
Holdoff_ms, 100, post-reset window in ms during which errors are ignored; cycles = Clk_Frequency*Holdoff_ms/1000 (>=1).
Stable_ms, 1000, error-free MONITOR time in ms that clears the retry count; cycles computed as above (>=1).
MaxRetries, 3, number of trips allowed before FAULT (>=0).

Ports:
ipClk  in  1  system clock.
ipReset  in  1  synchronous, active-high reset.
ipError  in  Channels  watchdog opError inputs, level.
ipMask  in  Channels  1 = channel enabled; takes effect the same cycle.
ipClear  in  1  leave FAULT; ignored in other states.
opSysReset  out  1  subsystem reset, registered.
opWdReset  out  1  watchdog re-arm, ORed into each watchdog kick (level-sensitive configuration).
opCause  out  Channels  one-hot; lowest-index channel that caused the last trip.
opRetries  out  $clog2(MaxRetries+1)  count of trips since the last stable period.
opFault  out  1  latched escalation flag.
opState  out  2  encoding: MONITOR=0, RESET=1, HOLDOFF=2, FAULT=3.

Behaviour:
- Register outputs: all outputs are registered, with no combinational path from input to output.
- Trip condition: Trig = |(ipError & ipMask), sampled in MONITOR only. opSysReset rises on the cycle after Trig is sampled.
- ipReset:
  - Has priority over everything else.
  - Next state is RESET with the pulse counter loaded.
  - opSysReset=1, opWdReset=1, opRetries=0, opCause=0, opFault=0.
  - Power-up therefore issues one full reset sequence.
- MONITOR:
  - On Trig with opRetries==MaxRetries: go to FAULT and set opFault=1.
  - On Trig otherwise: opRetries+1, opCause <= lowest set bit of (ipError & ipMask), go to RESET.
  - With no Trig: the stable counter decrements. At zero, opRetries <= 0 and the counter reloads.
  - The stable counter loads Stable cycles on every entry to MONITOR.
- RESET:
  - opSysReset=1 and opWdReset=1 for exactly ResetPulse_Cycles cycles, then HOLDOFF.
  - ipError is ignored.
- HOLDOFF:
  - opSysReset=0 and opWdReset=0 for exactly Holdoff cycles, then MONITOR.
  - ipError is ignored.
- FAULT:
  - opSysReset=1, opFault=1, opWdReset=0; ipError is ignored.
  - ipClear goes to RESET with opRetries=0, opCause=0, opFault=0.
- Held values: opCause is held until the next trip, ipClear or ipReset. opRetries saturates at MaxRetries.
- MaxRetries=0: the first trip goes directly to FAULT.
- A mask change mid-error: a newly unmasked channel with an active error trips on that cycle.
- Counters: each counter is sized with $clog2 of its load value and is a down-counter with no wrap.

Decomposition:
- Package watchdog_pkg:
  - state enum (MONITOR, RESET, HOLDOFF, FAULT) with fixed 2-bit encodings;
  - function ms_to_cycles(freq, ms);
  - function lowest_onehot(vector).
- One sub-module, sup_down_counter: a loadable, parameter-width down-counter with load, enable and zero flag. It is instantiated for the pulse/hold-off timer (shared, reloaded per state) and for the stable timer.

Test Plan:
Bench parameters: Clk_Frequency=1000 (1 ms = 1 cycle), Channels=4, ResetPulse_Cycles=4, Holdoff_ms=8, Stable_ms=20, MaxRetries=2.
1. Release ipReset -> opSysReset=opWdReset=1 for 4 cycles, then HOLDOFF for 8 cycles; opState=0 on cycle 12 after release; opRetries=0.
2. In MONITOR, ipError=0110, ipMask=1111 -> next cycle opSysReset=1, opCause=0010, opRetries=1; ipError=1111 during HOLDOFF causes no trip.
3. ipError=1000, ipMask=0111 held 50 cycles -> no trip; then ipMask=1111 -> trip with opCause=1000.
4. Three trips within the stable window -> opRetries 1, then 2, then FAULT: opFault=1, opSysReset held high for 100 cycles; ipClear -> RESET, opRetries=0, opCause=0.
5. Trip, then 20 error-free MONITOR cycles -> opRetries returns to 0 on cycle 20, not before.
6. ipReset asserted on cycle 2 of RESET -> pulse restarts at the full 4 cycles, opRetries=0, opCause=0.
